// File: rtl/htol_tx.sv
// Transmit half of a strobe-based CDC link: FIFO-buffered words leave as a held
// data bus plus a slow strobe whose rising edge the receiving domain captures on.
module htol_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADD_WIDTH  = 3,
  parameter int DIV        = 4
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  stb,
  output logic [ADD_WIDTH:0]    count,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ZERO = CNT_W'(0);
  localparam logic [ADD_WIDTH:0]   OCC_FULL = (ADD_WIDTH + 1)'(DEPTH);
  localparam logic [ADD_WIDTH:0]   OCC_ONE  = (ADD_WIDTH + 1)'(1);
  localparam logic [ADD_WIDTH:0]   OCC_ZERO = (ADD_WIDTH + 1)'(0);
  localparam logic [ADD_WIDTH-1:0] PTR_ONE  = ADD_WIDTH'(1);
  localparam logic [ADD_WIDTH-1:0] PTR_ZERO = ADD_WIDTH'(0);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2
  } state_t;

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [ADD_WIDTH-1:0]  wr_ptr_r;
  logic [ADD_WIDTH-1:0]  rd_ptr_r;
  logic [ADD_WIDTH:0]    count_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  stb_r;

  logic ready_s;
  logic push_s;
  logic pop_s;
  logic cnt_last_s;
  logic not_empty_s;

  // Handshake and pop decisions; a pop in HIGH sees occupancy before any same-edge push.
  always_comb begin
    ready_s     = ~rst & (count_r < OCC_FULL);
    push_s      = din_valid & ready_s;
    cnt_last_s  = (cnt_r == CNT_LAST);
    not_empty_s = (count_r != OCC_ZERO);
    pop_s       = 1'b0;
    case (state_r)
      IDLE:    pop_s = not_empty_s;
      SETUP:   pop_s = 1'b0;
      HIGH:    pop_s = cnt_last_s & not_empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // FIFO storage; contents are meaningless outside the pointer window, so no reset.
  always_ff @(posedge wclk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= OCC_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + OCC_ONE;
        2'b01:   count_r <= count_r - OCC_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Strobe sequencer: dout only moves on the falling strobe edge or from IDLE,
  // so it is stable for DIV cycles either side of every rising edge.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      dout_r  <= DATA_ZERO;
      stb_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          stb_r <= 1'b0;
          cnt_r <= CNT_ZERO;
          if (pop_s) begin
            dout_r  <= mem_r[rd_ptr_r];
            state_r <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_last_s) begin
            stb_r   <= 1'b1;
            cnt_r   <= CNT_ZERO;
            state_r <= HIGH;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        HIGH: begin
          if (cnt_last_s) begin
            stb_r <= 1'b0;
            cnt_r <= CNT_ZERO;
            if (pop_s) begin
              dout_r  <= mem_r[rd_ptr_r];
              state_r <= SETUP;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
          stb_r   <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready = ready_s;
  assign dout      = dout_r;
  assign stb       = stb_r;
  assign count     = count_r;
  assign busy      = (state_r != IDLE) | not_empty_s;

endmodule

// File: tb/tb_htol_tx.sv
// Self-checking bench for htol_tx: cycle tables for single-word latency plus
// scoreboarded sequences for backpressure, ordering, wrap and reset flush.
module tb_htol_tx;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DIV   = 4;

  logic          wclk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          stb;
  logic [AW:0]   count;
  logic          busy;

  always #5 wclk = ~wclk;

  htol_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADD_WIDTH(AW), .DIV(DIV)) dut (
    .wclk(wclk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .stb(stb), .count(count), .busy(busy)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          e_stb;
    logic [AW:0]   e_cnt;
    logic          e_busy;
    logic [DW-1:0] e_dout;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = -100;
  logic stb_prev = 1'b0;
  logic [DW-1:0] dout_prev = '0;
  logic [DW-1:0] exp_q[$];
  int rise_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: record an accepted word, advance, then score any strobe rise.
  task automatic tick();
    logic [DW-1:0] e;
    if (din_valid && din_ready) exp_q.push_back(din);
    @(posedge wclk);
    #1;
    cyc++;
    if (stb && !stb_prev) begin
      rise_cyc = cyc;
      rise_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got %0h expected no word", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          failures++;
          $display("FAIL sb_order: got %0h expected %0h", dout, e);
        end
      end
    end else if (stb && stb_prev) begin
      chk("dout_hold", dout, dout_prev);
    end
    stb_prev  = stb;
    dout_prev = dout;
  endtask

  // Assert reset mid-cycle, check the immediate state, then release.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_stb", stb, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_din_ready", din_ready, 0);
    exp_q.delete();
    stb_prev  = 1'b0;
    dout_prev = '0;
    din_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rel_din_ready", din_ready, 1);
  endtask

  task automatic run_single(input logic [DW-1:0] w, input string tag);
    vec_t tbl[11];
    tbl[0] = '{1'b1, w, 1'b0, 4'd1, 1'b1, 32'h0};
    for (int i = 1; i < 11; i++) begin
      tbl[i] = '{1'b0, 32'h0, 1'b0, 4'd0, 1'b1, w};
      if (i >= 5 && i <= 8) tbl[i].e_stb = 1'b1;
      if (i >= 9) tbl[i].e_busy = 1'b0;
    end
    for (int i = 0; i < 11; i++) begin
      din_valid = tbl[i].v;
      din       = tbl[i].d;
      tick();
      chk($sformatf("%s[%0d].stb", tag, i), stb, tbl[i].e_stb);
      chk($sformatf("%s[%0d].count", tag, i), count, tbl[i].e_cnt);
      chk($sformatf("%s[%0d].busy", tag, i), busy, tbl[i].e_busy);
      chk($sformatf("%s[%0d].dout", tag, i), dout, tbl[i].e_dout);
      chk($sformatf("%s[%0d].din_ready", tag, i), din_ready, 1);
    end
    din_valid = 1'b0;
  endtask

  initial begin
    int base;
    int acc_at[10];
    int guard;
    int sent;
    int steady;
    logic acc;
    logic pop_next;
    logic [AW:0] cnt_before;

    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Test 1: random prior activity, then reset mid-cycle.
    for (int i = 0; i < int'($urandom_range(1, 5)); i++) begin
      din_valid = 1'b1;
      din = $urandom;
      tick();
    end
    din_valid = 1'b0;
    for (int i = 0; i < int'($urandom_range(0, 12)); i++) tick();
    do_reset();

    // Test 2: single word latency.
    run_single(32'hA5A50001, "t2");

    // Test 3: fill past full and observe backpressure.
    rise_q.delete();
    base = cyc;
    for (int v = 1; v <= 10; v++) begin
      din = DW'(v);
      din_valid = 1'b1;
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 30) begin
        acc = din_ready;
        tick();
        guard++;
      end
      if (!acc) chk($sformatf("t3_accept_timeout_%0d", v), 0, 1);
      acc_at[v-1] = cyc - base;
      if (v == 9) begin
        chk("t3_count_full", count, 8);
        chk("t3_ready_full", din_ready, 0);
      end
    end
    din_valid = 1'b0;
    chk("t3_acc_word9_edge", acc_at[8], 9);
    chk("t3_acc_wordA_edge", acc_at[9], 11);
    chk("t3_count_afterA", count, 8);

    // Test 4: drain; order via scoreboard, spacing and busy fall here.
    guard = 0;
    while (busy && guard < 200) begin
      tick();
      guard++;
    end
    chk("t4_drain_done", busy, 0);
    chk("t4_rises", rise_q.size(), 10);
    for (int i = 1; i < rise_q.size(); i++)
      chk($sformatf("t4_spacing_%0d", i), rise_q[i] - rise_q[i-1], 8);
    if (rise_q.size() > 0) chk("t4_busy_fall", cyc - rise_q[rise_q.size()-1], 4);
    chk("t4_sb_empty", exp_q.size(), 0);

    // Test 5: hold occupancy at 3 across 40 words with push+pop edges.
    rise_q.delete();
    sent = 0;
    steady = 0;
    guard = 0;
    while ((sent < 40 || busy) && guard < 2000) begin
      pop_next   = stb && (cyc == rise_cyc + 3);
      cnt_before = count;
      din_valid  = (sent < 40) && ((count < 3) || (count == 3 && pop_next));
      din        = 32'h5000_0000 + DW'(sent);
      acc        = din_valid && din_ready;
      tick();
      guard++;
      if (acc) begin
        sent++;
        if (cnt_before == 3) begin
          steady++;
          chk("t5_count_hold", count, 3);
        end
      end
    end
    din_valid = 1'b0;
    chk("t5_sent", sent, 40);
    chk("t5_rises", rise_q.size(), 40);
    chk("t5_steady_edges", steady > 30, 1);
    chk("t5_sb_empty", exp_q.size(), 0);

    // Test 6: reset in HIGH with 5 words queued; they must never appear.
    for (int i = 0; i < 6; i++) begin
      din_valid = 1'b1;
      din = 32'h6000_0000 + DW'(i);
      tick();
    end
    din_valid = 1'b0;
    tick();
    chk("t6_pre_stb", stb, 1);
    chk("t6_pre_count", count, 5);
    do_reset();
    rise_q.delete();
    run_single(32'hDEAD0000, "t6");
    for (int i = 0; i < 20; i++) tick();
    chk("t6_rises", rise_q.size(), 1);
    chk("t6_sb_empty", exp_q.size(), 0);
    chk("t6_count", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
